hazard_int_ctrl: RTL and testbench
==================================

HAZARD_INT_CTRL -- requirements
Module: hazard_int_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- REG_ADDR_W, default 3: register-specifier width.
- PC_W, default 32: PC width.
- DRAIN_CYCLES, default 3: pipeline drain length before interrupt entry, range 1..15.
- RET_BUBBLES, default 3: bubble count after a RET reaches memory, range 1..15.
- INT_VECTOR, default 32'd0: PC loaded on interrupt entry.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 int_req  input  1  external interrupt request, level or pulse, sampled every cycle.
REQ-005 id_rsrc, id_rdst  input  REG_ADDR_W each  source registers of the instruction in decode.
REQ-006 id_use_rsrc, id_use_rdst  input  1 each  decode instruction reads that operand.
REQ-007 ex_mem_read  input  1  instruction in execute is a load or pop.
REQ-008 ex_rdst  input  REG_ADDR_W  destination of the instruction in execute.
REQ-009 branch_taken  input  1  execute resolved a taken branch or jump.
REQ-010 mem_ret  input  1  RET/RTI occupies the memory stage.
REQ-011 pc_stall, if_stall  output  1 each  hold PC; hold the IF/ID buffer.
REQ-012 if_flush, id_flush, ie_flush  output  1 each  bubble the IF/ID, ID/IE and IE/IM buffers.
REQ-013 pc_sel  output  2  PC source: 0 = increment, 1 = branch, 2 = popped, 3 = INT_VECTOR.
REQ-014 int_mem_sel  output  2  memory data source: 0 = normal, 1 = PC[15:0], 2 = PC[PC_W-1:16], 3 = flags.
REQ-015 int_busy  output  1  interrupt FSM is not IDLE.

Function
REQ-016 The block SHALL assert load-use stall when ex_mem_read=1 and ex_rdst matches an id operand whose use bit is set.
REQ-017 Load-use stall SHALL combinationally assert pc_stall, if_stall and id_flush for exactly that cycle.
REQ-018 Branch_taken SHALL combinationally assert if_flush and id_flush and set pc_sel=1, with priority over load-use stall.
REQ-019 On int_req, a 1-bit pending latch SHALL set and remain set until the FSM leaves IDLE; further requests while pending SHALL be ignored (no queueing).
REQ-020 The FSM SHALL have states IDLE, DRAIN, PUSH_LO, PUSH_HI, PUSH_FLG, VECTOR, RET_WAIT.
REQ-021 IDLE SHALL go to DRAIN when pending=1 and no RET_WAIT is in progress.
REQ-022 IDLE SHALL go to RET_WAIT when mem_ret=1; mem_ret SHALL win if both occur in the same cycle, and pending SHALL be retained.
REQ-023 DRAIN SHALL hold pc_stall=1 and if_flush=1 and load a 4-bit counter with DRAIN_CYCLES-1, decrementing each cycle; it SHALL exit to PUSH_LO at count 0.
REQ-024 PUSH_LO, PUSH_HI and PUSH_FLG SHALL each last one cycle, with int_mem_sel=1, 2 and 3 respectively, and pc_stall=1.
REQ-025 VECTOR SHALL last one cycle with pc_sel=3, if_flush=1 and id_flush=1, then return to IDLE.
REQ-026 RET_WAIT SHALL hold pc_stall=1 and if_flush=1 for RET_BUBBLES cycles.
REQ-027 On the final RET_WAIT cycle the block SHALL drive pc_sel=2 and return to IDLE, entering DRAIN on the next cycle if pending=1.
REQ-028 While the FSM is not IDLE, branch_taken and load-use SHALL be ignored, except that flushes SHALL OR together.
REQ-029 The counter SHALL not wrap: it SHALL saturate at 0 until the state changes.

Reset
REQ-030 Reset SHALL force the FSM to IDLE, pending=0, counter=0, all stall and flush outputs 0, pc_sel=0, int_mem_sel=0 and int_busy=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence with no further pushes.
REQ-032 The first int_req sampled after reset release SHALL be honoured.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the pc_sel and int_mem_sel encodings, and the default INT_VECTOR.
REQ-034 One sub-module, hazard_detect (the combinational load-use/branch logic), SHALL be instantiated; the FSM and counter SHALL remain in hazard_int_ctrl.

Verification
REQ-035 ex_mem_read=1, ex_rdst=3, id_rsrc=3, id_use_rsrc=1 -> pc_stall=if_stall=id_flush=1 for exactly 1 cycle; with id_use_rsrc=0 -> no stall.
REQ-036 Same-cycle load-use and branch_taken -> pc_sel=1, if_flush=id_flush=1, pc_stall=0.
REQ-037 int_req pulse with DRAIN_CYCLES=3 -> 3 DRAIN cycles, then int_mem_sel 1,2,3 on consecutive cycles, then pc_sel=3 for one cycle; int_busy high for 7 cycles.
REQ-038 mem_ret and int_req in the same cycle with RET_BUBBLES=3 -> 3 RET_WAIT cycles ending with pc_sel=2, one IDLE cycle, then the interrupt sequence.
REQ-039 Reset asserted during PUSH_HI -> all outputs 0 asynchronously, no PUSH_FLG after release, FSM in IDLE.

Source files
------------

// File: rtl/hazard_int_ctrl_pkg.sv
// Shared types for the hazard / interrupt-entry controller: FSM states,
// PC-source and memory-data-source encodings, default interrupt vector.
package hazard_int_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_LO,
        S_PUSH_HI,
        S_PUSH_FLG,
        S_VECTOR,
        S_RET_WAIT
    } int_state_e;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_POPPED = 2'd2,
        PC_VECTOR = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        MEM_NORMAL = 2'd0,
        MEM_PC_LO  = 2'd1,
        MEM_PC_HI  = 2'd2,
        MEM_FLAGS  = 2'd3
    } mem_sel_e;

    localparam logic [31:0] DEFAULT_INT_VECTOR = 32'd0;

    // Pipeline control bundle produced by both the hazard logic and the FSM.
    typedef struct packed {
        logic    pc_stall;
        logic    if_stall;
        logic    if_flush;
        logic    id_flush;
        pc_sel_e pc_sel;
    } pipe_ctl_t;

endpackage

// File: rtl/hazard_int_ctrl_detect.sv
// Combinational load-use stall and taken-branch flush detection for the
// instruction in decode against the instruction in execute.
module hazard_detect
    import hazard_int_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] id_rsrc,
    input  logic [REG_ADDR_W-1:0] id_rdst,
    input  logic                  id_use_rsrc,
    input  logic                  id_use_rdst,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rdst,
    input  logic                  branch_taken,
    output pipe_ctl_t             ctl
);

    logic load_use;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
        ctl      = '0;
        load_use = ex_mem_read &&
                   ((id_use_rsrc && (id_rsrc == ex_rdst)) ||
                    (id_use_rdst && (id_rdst == ex_rdst)));
        if (branch_taken) begin
            // The wrong-path instruction stalled by load-use is flushed anyway.
            ctl.if_flush = 1'b1;
            ctl.id_flush = 1'b1;
            ctl.pc_sel   = PC_BRANCH;
        end else if (load_use) begin
            ctl.pc_stall = 1'b1;
            ctl.if_stall = 1'b1;
            ctl.id_flush = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_int_ctrl.sv
// Pipeline hazard control plus the interrupt-entry / RET-recovery sequencer
// (drain, push PC low/high and flags, jump to vector; bubble after RET).
module hazard_int_ctrl
    import hazard_int_ctrl_pkg::*;
#(
    parameter int          REG_ADDR_W   = 3,
    parameter int          PC_W         = 32,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          RET_BUBBLES  = 3,
    parameter logic [31:0] INT_VECTOR   = DEFAULT_INT_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  int_req,
    input  logic [REG_ADDR_W-1:0] id_rsrc,
    input  logic [REG_ADDR_W-1:0] id_rdst,
    input  logic                  id_use_rsrc,
    input  logic                  id_use_rdst,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rdst,
    input  logic                  branch_taken,
    input  logic                  mem_ret,
    output logic                  pc_stall,
    output logic                  if_stall,
    output logic                  if_flush,
    output logic                  id_flush,
    output logic                  ie_flush,
    output logic [1:0]            pc_sel,
    output logic [1:0]            int_mem_sel,
    output logic                  int_busy
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] RET_LOAD   = 4'(RET_BUBBLES - 1);

    // Counters are 4 bits and the PC is pushed as two 16-bit halves.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || RET_BUBBLES < 1 || RET_BUBBLES > 15 ||
        PC_W < 17 || (PC_W < 32 && (INT_VECTOR >> PC_W) != '0)) begin : g_bad_params
        $error("hazard_int_ctrl: parameter out of range");
    end

    pipe_ctl_t  hz;
    pipe_ctl_t  fsm;
    mem_sel_e   mem_sel;
    int_state_e state;
    logic       pending;
    logic [3:0] cnt;
    logic       hz_live;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rsrc      (id_rsrc),
        .id_rdst      (id_rdst),
        .id_use_rsrc  (id_use_rsrc),
        .id_use_rdst  (id_use_rdst),
        .ex_mem_read  (ex_mem_read),
        .ex_rdst      (ex_rdst),
        .branch_taken (branch_taken),
        .ctl          (hz)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            pending <= pending | int_req;
            case (state)
                S_IDLE: begin
                    if (mem_ret) begin
                        state <= S_RET_WAIT;
                        cnt   <= RET_LOAD;
                    end else if (pending || int_req) begin
                        state   <= S_DRAIN;
                        cnt     <= DRAIN_LOAD;
                        pending <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (cnt == 4'd0) state <= S_PUSH_LO;
                    else             cnt   <= cnt - 4'd1;
                end
                S_PUSH_LO:  state <= S_PUSH_HI;
                S_PUSH_HI:  state <= S_PUSH_FLG;
                S_PUSH_FLG: state <= S_VECTOR;
                S_VECTOR:   state <= S_IDLE;
                S_RET_WAIT: begin
                    if (cnt == 4'd0) state <= S_IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        fsm     = '0;
        mem_sel = MEM_NORMAL;
        case (state)
            S_DRAIN: begin
                fsm.pc_stall = 1'b1;
                fsm.if_flush = 1'b1;
            end
            S_PUSH_LO: begin
                fsm.pc_stall = 1'b1;
                mem_sel      = MEM_PC_LO;
            end
            S_PUSH_HI: begin
                fsm.pc_stall = 1'b1;
                mem_sel      = MEM_PC_HI;
            end
            S_PUSH_FLG: begin
                fsm.pc_stall = 1'b1;
                mem_sel      = MEM_FLAGS;
            end
            S_VECTOR: begin
                fsm.if_flush = 1'b1;
                fsm.id_flush = 1'b1;
                fsm.pc_sel   = PC_VECTOR;
            end
            S_RET_WAIT: begin
                fsm.pc_stall = 1'b1;
                fsm.if_flush = 1'b1;
                if (cnt == 4'd0) fsm.pc_sel = PC_POPPED;
            end
            default: ;
        endcase
    end

    // Hazard stalls and PC steering only act in IDLE; flushes always merge.
    assign int_busy    = (state != S_IDLE);
    assign hz_live     = !reset && !int_busy;
    assign pc_stall    = fsm.pc_stall | (hz_live & hz.pc_stall);
    assign if_stall    = fsm.if_stall | (hz_live & hz.if_stall);
    assign if_flush    = fsm.if_flush | (!reset & hz.if_flush);
    assign id_flush    = fsm.id_flush | (!reset & hz.id_flush);
    assign ie_flush    = 1'b0;
    assign pc_sel      = int_busy ? fsm.pc_sel : (hz_live ? hz.pc_sel : PC_INC);
    assign int_mem_sel = mem_sel;

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per cycle, a
// negedge monitor pops and compares them against the DUT.
module tb_hazard_int_ctrl;

    localparam int AW    = 3;
    localparam int PCW   = 32;
    localparam int DRAIN = 3;
    localparam int RETB  = 3;

    logic          clk;
    logic          reset;
    logic          int_req;
    logic [AW-1:0] id_rsrc, id_rdst, ex_rdst;
    logic          id_use_rsrc, id_use_rdst, ex_mem_read, branch_taken, mem_ret;
    logic          pc_stall, if_stall, if_flush, id_flush, ie_flush, int_busy;
    logic [1:0]    pc_sel, int_mem_sel;

    hazard_int_ctrl #(
        .REG_ADDR_W   (AW),
        .PC_W         (PCW),
        .DRAIN_CYCLES (DRAIN),
        .RET_BUBBLES  (RETB),
        .INT_VECTOR   (32'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .int_req      (int_req),
        .id_rsrc      (id_rsrc),
        .id_rdst      (id_rdst),
        .id_use_rsrc  (id_use_rsrc),
        .id_use_rdst  (id_use_rdst),
        .ex_mem_read  (ex_mem_read),
        .ex_rdst      (ex_rdst),
        .branch_taken (branch_taken),
        .mem_ret      (mem_ret),
        .pc_stall     (pc_stall),
        .if_stall     (if_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ie_flush     (ie_flush),
        .pc_sel       (pc_sel),
        .int_mem_sel  (int_mem_sel),
        .int_busy     (int_busy)
    );

    // Model: a schedule of what each future busy cycle must look like.
    typedef enum {A_DRAIN, A_LO, A_HI, A_FLG, A_VEC, A_RET, A_RET_LAST} act_e;
    typedef struct {
        logic [9:0] v;
        int         cyc;
    } exp_t;

    act_e act_q[$];
    exp_t exp_q[$];
    bit   pending_m;
    int   n_tests;
    int   n_fail;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] actual_vec();
        return {pc_stall, if_stall, if_flush, id_flush, ie_flush, pc_sel, int_mem_sel, int_busy};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (pc_stall,if_stall,if_flush,id_flush,ie_flush,pc_sel,int_mem_sel,int_busy)",
                     name, got, exp);
        end
    endtask

    task automatic step(input logic ir, input logic mr, input logic br, input logic emr,
                        input logic [AW-1:0] erd, input logic [AW-1:0] rs, input logic [AW-1:0] rd,
                        input logic us, input logic ud);
        logic       lu, ps, is_, ifl, idf, busy;
        logic [1:0] psel, ms;
        act_e       a;
        @(posedge clk);
        #1;
        int_req = ir; mem_ret = mr; branch_taken = br; ex_mem_read = emr;
        ex_rdst = erd; id_rsrc = rs; id_rdst = rd; id_use_rsrc = us; id_use_rdst = ud;

        lu = emr && ((us && rs == erd) || (ud && rd == erd));
        ps = 0; is_ = 0; ifl = 0; idf = 0; psel = 0; ms = 0; busy = 0;
        if (act_q.size() == 0) begin
            ps   = lu && !br;
            is_  = ps;
            ifl  = br;
            idf  = br || lu;
            psel = br ? 2'd1 : 2'd0;
            if (mr) begin
                for (int i = 0; i < RETB; i++) act_q.push_back(i == RETB - 1 ? A_RET_LAST : A_RET);
                pending_m = pending_m || ir;
            end else if (pending_m || ir) begin
                for (int i = 0; i < DRAIN; i++) act_q.push_back(A_DRAIN);
                act_q.push_back(A_LO);
                act_q.push_back(A_HI);
                act_q.push_back(A_FLG);
                act_q.push_back(A_VEC);
                pending_m = 0;
            end
        end else begin
            a    = act_q.pop_front();
            busy = 1;
            case (a)
                A_DRAIN:    begin ps = 1; ifl = 1; end
                A_LO:       begin ps = 1; ms = 2'd1; end
                A_HI:       begin ps = 1; ms = 2'd2; end
                A_FLG:      begin ps = 1; ms = 2'd3; end
                A_VEC:      begin psel = 2'd3; ifl = 1; idf = 1; end
                A_RET:      begin ps = 1; ifl = 1; end
                A_RET_LAST: begin ps = 1; ifl = 1; psel = 2'd2; end
                default: ;
            endcase
            ifl = ifl || br;
            idf = idf || br || lu;
            pending_m = pending_m || ir;
        end
        exp_q.push_back('{v: {ps, is_, ifl, idf, 1'b0, psel, ms, busy}, cyc: cyc});
        cyc++;
    endtask

    task automatic step_idle();
        step(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle %0d", e.cyc), actual_vec(), e.v);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; pending_m = 0;
        // Reset with a live branch and load-use on the inputs: outputs must still be 0.
        reset = 1; int_req = 0; mem_ret = 0; branch_taken = 1; ex_mem_read = 1;
        ex_rdst = 3'd3; id_rsrc = 3'd3; id_rdst = 3'd0; id_use_rsrc = 1; id_use_rdst = 0;
        #2;
        check("reset_state", actual_vec(), 10'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0; branch_taken = 0; ex_mem_read = 0; id_use_rsrc = 0;

        // First request after reset, full entry sequence.
        step(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (8) step_idle();

        // Load-use on rsrc, then same registers with the use bit clear, then on rdst.
        step(0, 0, 0, 1, 3'd3, 3'd3, 3'd5, 1, 0);
        step(0, 0, 0, 1, 3'd3, 3'd3, 3'd5, 0, 0);
        step(0, 0, 0, 1, 3'd2, 3'd6, 3'd2, 0, 1);
        step_idle();

        // Branch with simultaneous load-use.
        step(0, 0, 1, 1, 3'd3, 3'd3, 3'd3, 1, 1);
        step_idle();

        // RET and request in the same cycle.
        step(1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (12) step_idle();

        // Branch and load-use during drain only contribute flushes.
        step(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        step(0, 0, 1, 1, 3'd1, 3'd1, 3'd0, 1, 0);
        step(0, 0, 0, 1, 3'd1, 3'd1, 3'd0, 1, 0);
        repeat (7) step_idle();

        // Reset during PUSH_HI abandons the sequence.
        step(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (5) step_idle();
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        check("reset_mid_push", actual_vec(), 10'b0);
        act_q.delete();
        pending_m = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        repeat (6) step_idle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) step_idle();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
